// File: rtl/ad3542_pkg.sv
// Shared definitions for the AD3542 dual-SDIO SPI link: decoder states, frame
// geometry and the default DAC code register addresses.
package ad3542_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INSTR,
      ST_DATA,
      ST_SKIP
   } state_e;

   localparam int INSTR_BITS         = 8;
   localparam int DATA_BITS_PER_SCLK = 2;
   localparam int PAIRS_PER_BYTE     = 8 / DATA_BITS_PER_SCLK;

   localparam logic [6:0] CH0_ADDR_DEFAULT = 7'h2B;
   localparam logic [6:0] CH1_ADDR_DEFAULT = 7'h2D;

   // Streaming address step; 7-bit arithmetic gives the modulo-128 wrap.
   function automatic logic [6:0] stepAddr(input logic [6:0] addr, input logic descend);
      return descend ? addr - 7'd1 : addr + 7'd1;
   endfunction

endpackage

// File: rtl/ad3542_edge_sync.sv
// Input synchronizer with a history flop and rise/fall detection.
module ad3542_edge_sync #(
   parameter int   STAGES     = 2,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic reset_x,
   input  logic sig_i,
   output logic rise_o,
   output logic fall_o
);

   localparam int PRIME_MAX = STAGES + 1;
   localparam int CNT_W     = $clog2(PRIME_MAX + 1);

   logic             level;
   logic             prev_q;
   logic [CNT_W-1:0] prime_q;
   logic             primed;

   generate
      if (STAGES == 0) begin : g_direct
         assign level = sig_i;
      end else begin : g_pipe
         logic [STAGES-1:0] pipe_q;
         always_ff @(posedge clk) begin
            if (!reset_x) begin
               pipe_q <= {STAGES{IDLE_LEVEL}};
            end else begin
               pipe_q[0] <= sig_i;
               for (int i = 1; i < STAGES; i++) begin
                  pipe_q[i] <= pipe_q[i-1];
               end
            end
         end
         assign level = pipe_q[STAGES-1];
      end
   endgenerate

   // Edges are masked until the pipe has flushed its reset value, so a line
   // held away from its idle level across reset does not fake an edge.
   always_ff @(posedge clk) begin
      if (!reset_x) begin
         prev_q  <= IDLE_LEVEL;
         prime_q <= '0;
      end else begin
         prev_q <= level;
         if (!primed) begin
            prime_q <= prime_q + 1'b1;
         end
      end
   end

   assign primed = (prime_q == CNT_W'(PRIME_MAX));
   assign rise_o = primed & ~prev_q & level;
   assign fall_o = primed & prev_q & ~level;

endmodule

// File: rtl/ad3542_spi_target.sv
// Receive side of the AD3542 dual-SDIO SPI link: decodes frames into a
// register-write stream and shadows the two DAC codes until ldac falls.
module ad3542_spi_target
   import ad3542_pkg::*;
#(
   parameter int         SYNC_STAGES  = 2,
   parameter bit         ADDR_DESCEND = 1'b1,
   parameter logic [6:0] CH0_ADDR     = CH0_ADDR_DEFAULT,
   parameter logic [6:0] CH1_ADDR     = CH1_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_x,
   input  logic        spi_sclk,
   input  logic        spi_cs,
   input  logic        spi_sdio0,
   input  logic        spi_sdio1,
   input  logic        ldac,
   output logic        wr_valid,
   output logic [6:0]  wr_addr,
   output logic [7:0]  wr_data,
   output logic        rd_req,
   output logic        frame_done,
   output logic        frame_err,
   output logic [15:0] dac_0,
   output logic [15:0] dac_1
);

   localparam logic [6:0] CH0_LSB_ADDR = stepAddr(CH0_ADDR, ADDR_DESCEND);
   localparam logic [6:0] CH1_LSB_ADDR = stepAddr(CH1_ADDR, ADDR_DESCEND);

   logic       sclkRise, sclkFall;
   logic       csRise, csFall;
   logic       ldacRise, ldacFall;
   logic       unusedEdges;
   logic [1:0] sdioSync;

   state_e     state_q;
   logic [7:0] shift_q;
   logic [2:0] count_q;
   logic [6:0] addr_q;
   logic       byteDone_q, rdPend_q;
   logic       wrValid_q, rdReq_q, frameDone_q, frameErr_q;
   logic [6:0] wrAddr_q;
   logic [7:0] wrData_q;
   logic [15:0] shadow0_q, shadow1_q, dac0_q, dac1_q;
   logic [7:0] instrShift_d, dataShift_d;

   ad3542_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sclkSync (
      .clk(clk), .reset_x(reset_x), .sig_i(spi_sclk), .rise_o(sclkRise), .fall_o(sclkFall));
   ad3542_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_csSync (
      .clk(clk), .reset_x(reset_x), .sig_i(spi_cs), .rise_o(csRise), .fall_o(csFall));
   ad3542_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_ldacSync (
      .clk(clk), .reset_x(reset_x), .sig_i(ldac), .rise_o(ldacRise), .fall_o(ldacFall));

   assign unusedEdges = sclkFall | ldacRise;

   // Data lines get the same depth as sclk so each sample lines up with its rise.
   generate
      if (SYNC_STAGES == 0) begin : g_sdioDirect
         assign sdioSync = {spi_sdio1, spi_sdio0};
      end else begin : g_sdioPipe
         logic [1:0] sdioPipe_q [SYNC_STAGES];
         always_ff @(posedge clk) begin
            if (!reset_x) begin
               for (int i = 0; i < SYNC_STAGES; i++) begin
                  sdioPipe_q[i] <= 2'b00;
               end
            end else begin
               sdioPipe_q[0] <= {spi_sdio1, spi_sdio0};
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sdioPipe_q[i] <= sdioPipe_q[i-1];
               end
            end
         end
         assign sdioSync = sdioPipe_q[SYNC_STAGES-1];
      end
   endgenerate

   assign instrShift_d = {shift_q[6:0], sdioSync[0]};
   assign dataShift_d  = {shift_q[5:0], sdioSync[1], sdioSync[0]};

   // Frame decoder. A completed byte or read instruction is flagged first and
   // turned into its strobe on the following clock.
   always_ff @(posedge clk) begin
      if (!reset_x) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         count_q     <= '0;
         addr_q      <= '0;
         byteDone_q  <= 1'b0;
         rdPend_q    <= 1'b0;
         wrValid_q   <= 1'b0;
         wrAddr_q    <= '0;
         wrData_q    <= '0;
         rdReq_q     <= 1'b0;
         frameDone_q <= 1'b0;
         frameErr_q  <= 1'b0;
      end else begin
         wrValid_q   <= byteDone_q;
         rdReq_q     <= rdPend_q;
         byteDone_q  <= 1'b0;
         rdPend_q    <= 1'b0;
         frameDone_q <= 1'b0;
         frameErr_q  <= 1'b0;

         if (byteDone_q) begin
            wrAddr_q <= addr_q;
            wrData_q <= shift_q;
            addr_q   <= stepAddr(addr_q, ADDR_DESCEND);
         end

         if (csRise) begin
            state_q     <= ST_IDLE;
            frameDone_q <= 1'b1;
            frameErr_q  <= ((state_q == ST_INSTR) || (state_q == ST_DATA)) && (count_q != 3'd0);
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (csFall) begin
                     state_q <= ST_INSTR;
                     count_q <= '0;
                  end
               end
               ST_INSTR: begin
                  if (sclkRise) begin
                     shift_q <= instrShift_d;
                     if (count_q == 3'(INSTR_BITS - 1)) begin
                        count_q <= '0;
                        if (instrShift_d[7]) begin
                           rdPend_q <= 1'b1;
                           state_q  <= ST_SKIP;
                        end else begin
                           addr_q  <= instrShift_d[6:0];
                           state_q <= ST_DATA;
                        end
                     end else begin
                        count_q <= count_q + 3'd1;
                     end
                  end
               end
               ST_DATA: begin
                  if (sclkRise) begin
                     shift_q <= dataShift_d;
                     if (count_q == 3'(PAIRS_PER_BYTE - 1)) begin
                        count_q    <= '0;
                        byteDone_q <= 1'b1;
                     end else begin
                        count_q <= count_q + 3'd1;
                     end
                  end
               end
               ST_SKIP: begin
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   // Shadows follow the write strobe; ldac copies them out. Both use the
   // pre-edge shadow, so a coincident write only reaches the shadow.
   always_ff @(posedge clk) begin
      if (!reset_x) begin
         shadow0_q <= '0;
         shadow1_q <= '0;
         dac0_q    <= '0;
         dac1_q    <= '0;
      end else begin
         if (ldacFall) begin
            dac0_q <= shadow0_q;
            dac1_q <= shadow1_q;
         end
         if (wrValid_q) begin
            if (wrAddr_q == CH0_ADDR)     shadow0_q[15:8] <= wrData_q;
            if (wrAddr_q == CH0_LSB_ADDR) shadow0_q[7:0]  <= wrData_q;
            if (wrAddr_q == CH1_ADDR)     shadow1_q[15:8] <= wrData_q;
            if (wrAddr_q == CH1_LSB_ADDR) shadow1_q[7:0]  <= wrData_q;
         end
      end
   end

   assign wr_valid   = wrValid_q;
   assign wr_addr    = wrAddr_q;
   assign wr_data    = wrData_q;
   assign rd_req     = rdReq_q;
   assign frame_done = frameDone_q;
   assign frame_err  = frameErr_q;
   assign dac_0      = dac0_q;
   assign dac_1      = dac1_q;

endmodule

// File: tb/tb_ad3542_spi_target.sv
// Directed bench for ad3542_spi_target: drives SPI frames at sclk = clk/2 and
// checks the write stream, frame status and DAC outputs against a frame model.
module tb_ad3542_spi_target;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        reset_x;
   logic        spi_sclk, spi_cs, spi_sdio0, spi_sdio1, ldac;
   logic        wr_valid, rd_req, frame_done, frame_err;
   logic [6:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [15:0] dac_0, dac_1;

   int checks = 0;
   int passes = 0;

   // Model state: expected write stream, frame outcomes, read count, DAC codes.
   logic [14:0] expWrQ [$];
   bit          expErrQ [$];
   int          expRd = 0;
   logic [14:0] wrEntry;
   logic [15:0] modelShadow0 = '0, modelShadow1 = '0;
   logic [15:0] modelDac0 = '0, modelDac1 = '0;
   bit          inReset = 1'b1;
   bit          dacStable = 1'b0;
   int          sclkHalf = 1;

   always #5 clk = ~clk;

   ad3542_spi_target #(
      .SYNC_STAGES(S), .ADDR_DESCEND(1'b1), .CH0_ADDR(7'h2B), .CH1_ADDR(7'h2D)
   ) dut (
      .clk(clk), .reset_x(reset_x), .spi_sclk(spi_sclk), .spi_cs(spi_cs),
      .spi_sdio0(spi_sdio0), .spi_sdio1(spi_sdio1), .ldac(ldac),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .rd_req(rd_req),
      .frame_done(frame_done), .frame_err(frame_err), .dac_0(dac_0), .dac_1(dac_1)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
   endtask

   // A register write as seen from outside: queue it and fold it into the shadows.
   task automatic expectWrite(input logic [6:0] addr, input logic [7:0] data);
      expWrQ.push_back({addr, data});
      case (addr)
         7'h2B: modelShadow0[15:8] = data;
         7'h2A: modelShadow0[7:0]  = data;
         7'h2D: modelShadow1[15:8] = data;
         7'h2C: modelShadow1[7:0]  = data;
         default: ;
      endcase
   endtask

   // Per-cycle compare of every strobe and, when settled, the DAC outputs.
   always @(negedge clk) begin
      if (!inReset) begin
         if (wr_valid) begin
            checkOutput("writeExpected", expWrQ.size() > 0, 1);
            if (expWrQ.size() > 0) begin
               wrEntry = expWrQ.pop_front();
               checkOutput("wrAddr", wr_addr, wrEntry[14:8]);
               checkOutput("wrData", wr_data, wrEntry[7:0]);
            end
         end
         if (rd_req) begin
            checkOutput("rdReqExpected", expRd > 0, 1);
            if (expRd > 0) expRd--;
         end
         if (frame_done) begin
            checkOutput("frameDoneExpected", expErrQ.size() > 0, 1);
            if (expErrQ.size() > 0) checkOutput("frameErr", frame_err, expErrQ.pop_front());
         end
         checkOutput("frameErrWithoutDone", frame_err & ~frame_done, 0);
         if (dacStable) begin
            checkOutput("dac0", dac_0, modelDac0);
            checkOutput("dac1", dac_1, modelDac1);
         end
      end
   end

   task automatic sclkPulse(input logic d1, input logic d0);
      spi_sclk  = 1'b0;
      spi_sdio1 = d1;
      spi_sdio0 = d0;
      repeat (sclkHalf) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (sclkHalf) @(negedge clk);
   endtask

   task automatic csLow();
      spi_cs = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic csHigh(input bit expErr);
      expErrQ.push_back(expErr);
      spi_cs   = 1'b1;
      spi_sclk = 1'b0;
      repeat (S + 4) @(negedge clk);
   endtask

   task automatic sendInstr(input logic [7:0] instr, input int nBits);
      for (int i = 0; i < nBits; i++) sclkPulse(1'b0, instr[7-i]);
   endtask

   task automatic sendPairs(input logic [7:0] b, input int nPairs);
      for (int p = 0; p < nPairs; p++) sclkPulse(b[7-2*p], b[6-2*p]);
   endtask

   // Complete write frame; byte i lands at startAddr - i (mod 128).
   task automatic applyStimulus(input logic [6:0] startAddr, input logic [31:0] bytes, input int nBytes);
      for (int i = 0; i < nBytes; i++) expectWrite(7'(startAddr - i), bytes[31-8*i -: 8]);
      csLow();
      sendInstr({1'b0, startAddr}, 8);
      for (int i = 0; i < nBytes; i++) sendPairs(bytes[31-8*i -: 8], 4);
      csHigh(1'b0);
   endtask

   task automatic pulseLdac();
      dacStable = 1'b0;
      modelDac0 = modelShadow0;
      modelDac1 = modelShadow1;
      ldac = 1'b0;
      repeat (S + 3) @(negedge clk);
      dacStable = 1'b1;
      ldac = 1'b1;
      repeat (S + 3) @(negedge clk);
   endtask

   task automatic applyReset();
      inReset   = 1'b1;
      dacStable = 1'b0;
      reset_x   = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("rstWrValid", wr_valid, 0);
      checkOutput("rstWrAddr", wr_addr, 0);
      checkOutput("rstWrData", wr_data, 0);
      checkOutput("rstRdReq", rd_req, 0);
      checkOutput("rstFrameDone", frame_done, 0);
      checkOutput("rstFrameErr", frame_err, 0);
      checkOutput("rstDac0", dac_0, 0);
      checkOutput("rstDac1", dac_1, 0);
      expWrQ.delete();
      expErrQ.delete();
      expRd = 0;
      modelShadow0 = '0;
      modelShadow1 = '0;
      modelDac0 = '0;
      modelDac1 = '0;
      reset_x = 1'b1;
      repeat (S + 4) @(negedge clk);
      inReset   = 1'b0;
      dacStable = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reset_x   = 1'b0;
      spi_sclk  = 1'b0;
      spi_cs    = 1'b1;
      spi_sdio0 = 1'b0;
      spi_sdio1 = 1'b0;
      ldac      = 1'b1;
      applyReset();

      // CH0 write stays in the shadow until ldac falls.
      applyStimulus(7'h2B, 32'hABCD_0000, 2);
      checkOutput("dac0BeforeLdac", dac_0, 16'h0000);
      pulseLdac();
      checkOutput("dac0AfterLdac", dac_0, 16'hABCD);

      // Read instruction followed by 8 ignored sclks.
      expRd++;
      csLow();
      sendInstr(8'hAB, 8);
      sendPairs(8'h5A, 4);
      sendPairs(8'hA5, 4);
      csHigh(1'b0);

      // Descending address wraps from 7'h00 to 7'h7F.
      applyStimulus(7'h00, 32'h1122_0000, 2);

      // Partial data byte, then partial instruction.
      csLow();
      sendInstr(8'h10, 8);
      sendPairs(8'hC0, 2);
      csHigh(1'b1);
      csLow();
      sendInstr(8'h2B, 3);
      csHigh(1'b1);

      applyStimulus(7'h2D, 32'h5566_0000, 2);
      pulseLdac();
      checkOutput("dac1AfterLdac", dac_1, 16'h5566);

      // ldac falls in the same cycle as the CH1 LSB write strobe.
      expectWrite(7'h2D, 8'h12);
      csLow();
      sendInstr(8'h2D, 8);
      sendPairs(8'h12, 4);
      sendPairs(8'h34, 3);
      sclkPulse(1'b0, 1'b0);
      spi_sclk = 1'b0;
      @(negedge clk);
      dacStable = 1'b0;
      modelDac0 = modelShadow0;
      modelDac1 = modelShadow1;
      expectWrite(7'h2C, 8'h34);
      ldac = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("collisionStrobe", wr_valid, 1);
      repeat (S + 2) @(negedge clk);
      dacStable = 1'b1;
      checkOutput("dac1Collision", dac_1, 16'h1266);
      ldac = 1'b1;
      repeat (3) @(negedge clk);
      csHigh(1'b0);
      pulseLdac();
      checkOutput("dac1AfterSecondLdac", dac_1, 16'h1234);

      // Reset mid-frame, then the abandoned cs rise and a clean streamed frame.
      csLow();
      sendInstr(8'h2B, 8);
      sendPairs(8'h99, 2);
      applyReset();
      csHigh(1'b0);
      applyStimulus(7'h2D, 32'h7FFF_7FFF, 4);
      pulseLdac();
      checkOutput("loopDac0", dac_0, 16'h7FFF);
      checkOutput("loopDac1", dac_1, 16'h7FFF);

      checkOutput("pendingWrites", expWrQ.size(), 0);
      checkOutput("pendingFrames", expErrQ.size(), 0);
      checkOutput("pendingReads", expRd, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ad3542_spi_target.md
Name: ad3542_spi_target

Overview:
- Receive-side model of the AD3542 dual-SDIO SPI link.
- Samples the sclk, cs, sdio0 and sdio1 lines driven by an ad3542_iface instance, decodes instruction and data phases into a register-write stream, and shadows the two 16-bit DAC input codes.
- Shadow codes transfer to the outputs on an ldac falling edge.
- Used for on-board FPGA loopback checks and as a synthesizable bench responder.

Parameters:
- SYNC_STAGES, 2: input synchronizer depth (0 allowed when the driver shares clk).
- ADDR_DESCEND, 1: 1 = streaming address decrements per data byte; 0 = increments.
- CH0_ADDR, 7'h2B: address of the CH0 code MSB byte; the LSB byte is at the next streamed address.
- CH1_ADDR, 7'h2D: same as CH0_ADDR, for CH1.

Ports:
- clk  in  1  system clock, the same clock as the transmitter (max 132 MHz)
- reset_x  in  1  synchronous reset, active-low
- spi_sclk  in  1  SPI clock, at most clk/2
- spi_cs  in  1  chip select, active-low
- spi_sdio0  in  1  instruction bit / data low bit
- spi_sdio1  in  1  data high bit
- ldac  in  1  load DAC, active-low
- wr_valid  out  1  one-cycle strobe per completed data byte
- wr_addr  out  7  address of the strobed byte
- wr_data  out  8  strobed byte
- rd_req  out  1  one-cycle pulse when a read instruction is decoded
- frame_done  out  1  one-cycle pulse on cs rising edge
- frame_err  out  1  one-cycle pulse on cs rising edge when the frame ended mid-byte
- dac_0  out  16  CH0 code, loaded on ldac
- dac_1  out  16  CH1 code, loaded on ldac

Behaviour:
- Reset (reset_x=0 at a clk edge): all outputs 0, shadow registers 0, FSM in IDLE. Synchronizer flops reset to idle levels (sclk=0, cs=1, ldac=1).
- Sampling
  - All inputs pass through SYNC_STAGES flops, plus one history flop.
  - sclk rise = prev 0 and cur 1. Data is sampled on the same clk as the detected rise.
  - cs fall/rise and ldac fall are detected the same way.
- FSM states: IDLE, INSTR, DATA, SKIP.
  - IDLE -> INSTR on cs fall.
  - INSTR: shift sdio0 MSB-first on 8 sclk rises. Bit7 = R/W (1 = read), bits 6:0 = start address.
    - After the 8th rise: write -> DATA. Read -> pulse rd_req the next cycle, then SKIP.
  - DATA: dual mode, 2 bits per sclk rise, {sdio1, sdio0} shifted in MSB-pair first; 4 rises form one byte.
    - wr_valid is asserted 1 cycle after the 4th rise, carrying the current address.
    - The address then steps ±1 per ADDR_DESCEND and wraps modulo 128 (7'h00 -> 7'h7F when descending).
  - SKIP: ignore sclk until cs rise.
  - Any state -> IDLE on cs rise. frame_done pulses 1 cycle after the cs rise is detected.
  - frame_err pulses together with frame_done when the frame ends with:
    - a partial instruction (1–7 bits), or
    - a partial data byte (1–3 rises).
    A partial byte is discarded and produces no wr_valid.
  - A cs fall while not IDLE cannot occur (a cs rise always precedes it); no special handling is required.
- Shadow registers
  - On wr_valid with wr_addr == CHx_ADDR: the shadow MSB takes the data.
  - On the next streamed address (CHx_ADDR ∓ 1 per ADDR_DESCEND): the shadow LSB takes the data.
- LDAC
  - On an ldac fall, dac_0/dac_1 <= shadows, registered 1 cycle after detection.
  - If an ldac fall and a wr_valid to a shadow byte occur in the same cycle, the pre-write shadow value is loaded. The write lands in the shadow only.
- Latency: from the sclk edge at the pins to wr_valid = SYNC_STAGES + 2 clk cycles.
- reset_x low mid-frame aborts the frame. After release, the FSM waits in IDLE for the next cs fall; no error pulse is generated for the aborted frame.

Decomposition:
- Shared package ad3542_pkg:
  - FSM state enum.
  - INSTR_BITS=8, DATA_BITS_PER_SCLK=2.
  - Default CH0/CH1 register addresses, shared with ad3542_iface.
- One sub-module, ad3542_edge_sync: parameterized synchronizer with rise/fall detect, instantiated once for each of sclk, cs and ldac.
- sdio0/sdio1 use the same sync depth without the edge logic.

Test Plan:
- Write frame: instr 8'h2B, data bytes 8'hAB,8'hCD (descending) -> wr_valid twice: (7'h2B, 8'hAB), (7'h2A, 8'hCD). frame_done=1, frame_err=0, dac_0 unchanged until ldac fall, then dac_0=16'hABCD.
- Read frame: instr 8'hAB (R/W=1, addr 7'h2B) plus 8 sclks -> rd_req pulses once, no wr_valid, frame_done pulses.
- Wrap-around: ADDR_DESCEND=1, start addr 7'h00, 2 bytes -> wr_addr 7'h00 then 7'h7F.
- Truncated frame: cs rises after 2 data sclks -> no wr_valid for that byte, frame_err=1 coincident with frame_done.
- Collision: ldac fall in the same cycle as the wr_valid writing the CH1 LSB -> dac_1 gets the old shadow; the next ldac fall gives the new value.
- Loopback: drive from ad3542_iface with SW mode 2 (16'h7FFF) at sclk = clk/2 -> dac_0 = dac_1 = 16'h7FFF after ldac. Reset_x pulsed mid-frame -> all outputs 0 and a clean decode of the next frame.
